softmax_stream_sink: RTL and testbench

- AXI-stream receiver for the softmax unit output: accepts one N x N probability matrix per frame (row-major, tlast on final beat) and stores it in a ping-pong buffer.
- Exposes a random-access read port so the downstream attention-times-V matmul can consume a completed matrix while the next one is being written.
- Sits directly on the softmax top's output stream.

---
 rtl/softmax_stream_sink_pkg.sv | 11 +
 rtl/softmax_stream_sink_if.sv | 12 +
 rtl/softmax_stream_sink_sdp_ram.sv | 24 ++
 rtl/softmax_stream_sink.sv | 96 +++++++++
 tb/tb_softmax_stream_sink.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/softmax_stream_sink_pkg.sv
// softmax_pkg: shared types and helpers for the softmax stream sink
//   bank_t          ping-pong bank index
//   a_w(n)          per-bank address width for an n x n matrix
//   close_reason_e  why a frame closed (normal, early tlast, missing tlast)
package softmax_pkg;
  typedef logic [0:0] bank_t;
  typedef enum logic [1:0] {NORMAL, EARLY_TLAST, MISSING_TLAST} close_reason_e;
  function automatic int a_w(int n);
    return 2 * $clog2(n);
  endfunction
endpackage

// File: rtl/softmax_stream_sink_if.sv
// axi_stream_if: AXI-stream beat bundle
//   tdata/tvalid/tlast driven by the producer (axi_out), tready by the consumer (axi_in)
interface axi_stream_if #(
  parameter int D_W = 8
);
  logic [D_W-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  modport axi_out(output tdata, output tvalid, output tlast, input tready);
  modport axi_in(input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/softmax_stream_sink_sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port
//   clk, rst          clock, sync reset (clears only the read register)
//   we, waddr, wdata  write port
//   re, raddr, rdata  read port; rdata updates the cycle after re, holds otherwise
module sdp_ram #(
  parameter int D_W = 8,
  parameter int A_W = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [A_W-1:0] waddr,
  input  logic [D_W-1:0] wdata,
  input  logic           re,
  input  logic [A_W-1:0] raddr,
  output logic [D_W-1:0] rdata
);
  logic [D_W-1:0] mem [2**A_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/softmax_stream_sink.sv
// softmax_stream_sink: stores N x N softmax frames from an AXI stream into a ping-pong buffer
//   clk, rst         clock, sync active-high reset
//   qin              input stream (tready = current write bank not full)
//   rd_bank_valid    current read bank holds a complete frame
//   rd_en, rd_addr   read strobe and element address row*N+col
//   rd_data          registered read data, holds when no valid read
//   rd_done          release the current read bank
//   frame_err        one-cycle pulse when tlast and the element counter disagree
//   frame_cnt/err_cnt  closed-frame and error counters, present with SOFTMAX_SINK_STATS_EN
module softmax_stream_sink
  import softmax_pkg::*;
#(
  parameter int D_W = 8,
  parameter int MATRIXSIZE_W = 16,
  parameter int N = 32,
  localparam int A_W = a_w(N)
) (
  input  logic           clk,
  input  logic           rst,
  axi_stream_if.axi_in   qin,
  output logic           rd_bank_valid,
  input  logic           rd_en,
  input  logic [A_W-1:0] rd_addr,
  output logic [D_W-1:0] rd_data,
  input  logic           rd_done,
  output logic           frame_err
`ifdef SOFTMAX_SINK_STATS_EN
  ,
  output logic [15:0]    frame_cnt,
  output logic [15:0]    err_cnt
`endif
);
  localparam int L = A_W / 2;
  logic [1:0] full;
  bank_t wr_bank, rd_bank;
  logic [MATRIXSIZE_W-1:0] row, col;
  logic accept, row_end, at_end, close, err, release_bank;
  close_reason_e reason;
  always_comb begin
    accept = qin.tvalid & qin.tready;
    row_end = col == MATRIXSIZE_W'(N - 1);
    at_end = row_end && row == MATRIXSIZE_W'(N - 1);
    reason = (qin.tlast && !at_end) ? EARLY_TLAST : (!qin.tlast && at_end) ? MISSING_TLAST : NORMAL;
    close = accept && (qin.tlast || at_end);
    err = close && reason != NORMAL;
    release_bank = rd_done && full[rd_bank];
  end
  assign qin.tready = ~full[wr_bank];
  assign rd_bank_valid = full[rd_bank];
  // close and release always hit different banks, so both full updates can land together
  always_ff @(posedge clk)
    if (rst) begin
      full <= '0;
      wr_bank <= '0;
      rd_bank <= '0;
      row <= '0;
      col <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err;
      if (close) begin
        full[wr_bank] <= 1'b1;
        wr_bank <= ~wr_bank;
        row <= '0;
        col <= '0;
      end else if (accept) begin
        col <= row_end ? '0 : col + MATRIXSIZE_W'(1);
        row <= row_end ? row + MATRIXSIZE_W'(1) : row;
      end
      if (release_bank) begin
        full[rd_bank] <= 1'b0;
        rd_bank <= ~rd_bank;
      end
    end
`ifdef SOFTMAX_SINK_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      frame_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (close) frame_cnt <= frame_cnt + 16'd1;
      if (err) err_cnt <= err_cnt + 16'd1;
    end
`endif
  // bank index is the RAM address MSB so both banks share one array
  sdp_ram #(.D_W(D_W), .A_W(A_W + 1)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(accept),
    .waddr({wr_bank, row[L-1:0], col[L-1:0]}),
    .wdata(qin.tdata),
    .re(rd_en && rd_bank_valid),
    .raddr({rd_bank, rd_addr}),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_softmax_stream_sink.sv
// tb_softmax_stream_sink: scoreboard bench for the softmax stream sink (N=4, D_W=8)
module tb_softmax_stream_sink;
  import softmax_pkg::*;
  localparam int N = 4;
  localparam int D_W = 8;
  localparam int A_W = a_w(N);
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axi_stream_if #(.D_W(D_W)) qin();
  logic rd_en = 1'b0;
  logic rd_done = 1'b0;
  logic [A_W-1:0] rd_addr = '0;
  logic rd_bank_valid, frame_err;
  logic [D_W-1:0] rd_data;
`ifdef SOFTMAX_SINK_STATS_EN
  logic [15:0] frame_cnt, err_cnt;
`endif
  softmax_stream_sink #(.D_W(D_W), .MATRIXSIZE_W(16), .N(N)) dut (
    .clk(clk),
    .rst(rst),
    .qin(qin),
    .rd_bank_valid(rd_bank_valid),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_done(rd_done),
    .frame_err(frame_err)
`ifdef SOFTMAX_SINK_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
`endif
  );
  int checks = 0;
  int errors = 0;
  int stalls = 0;
  logic [7:0] model [2][N*N];
  logic [1:0] full_m;
  int wb, rb, pos, fcnt, ecnt;
  logic [7:0] last_exp;
  logic [7:0] sb [$];
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic model_reset();
    full_m = '0;
    wb = 0;
    rb = 0;
    pos = 0;
    fcnt = 0;
    ecnt = 0;
    last_exp = '0;
  endtask
  task automatic send_beat(input logic [7:0] d, input logic last);
    int w;
    logic at_end, cl;
    close_reason_e r;
    w = 0;
    qin.tvalid = 1'b1;
    qin.tdata = d;
    qin.tlast = last;
    while (!qin.tready && w < 50) begin
      @(negedge clk);
      w++;
    end
    stalls += w;
    if (!qin.tready) begin
      check("tready_timeout", 0, 1);
      return;
    end
    model[wb][pos] = d;
    at_end = pos == N*N-1;
    cl = last || at_end;
    r = (last && !at_end) ? EARLY_TLAST : (!last && at_end) ? MISSING_TLAST : NORMAL;
    if (cl) begin
      full_m[wb] = 1'b1;
      wb ^= 1;
      pos = 0;
      fcnt++;
      if (r != NORMAL) ecnt++;
    end else pos++;
    @(negedge clk);
    check("frame_err", frame_err, (cl && r != NORMAL) ? 1 : 0);
    check("rd_bank_valid", rd_bank_valid, full_m[rb]);
    check("tready", qin.tready, !full_m[wb]);
  endtask
  task automatic send_frame(input logic [7:0] base, input int nbeats, input int last_idx);
    for (int i = 0; i < nbeats; i++) send_beat(base + 8'(i), i == last_idx);
    qin.tvalid = 1'b0;
    qin.tlast = 1'b0;
`ifdef SOFTMAX_SINK_STATS_EN
    check("frame_cnt", frame_cnt, fcnt);
    check("err_cnt", err_cnt, ecnt);
`endif
  endtask
  task automatic rd(input int a);
    rd_en = 1'b1;
    rd_addr = A_W'(a);
    if (full_m[rb]) last_exp = model[rb][a];
    sb.push_back(last_exp);
    @(negedge clk);
    rd_en = 1'b0;
    check($sformatf("rd_data[%0d]", a), rd_data, sb.pop_front());
  endtask
  task automatic release_bank();
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    if (full_m[rb]) begin
      full_m[rb] = 1'b0;
      rb ^= 1;
    end
    check("rel_valid", rd_bank_valid, full_m[rb]);
    check("rel_tready", qin.tready, !full_m[wb]);
  endtask
  initial begin
    qin.tvalid = 1'b0;
    qin.tdata = '0;
    qin.tlast = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", rd_bank_valid, 0);
    check("rst_tready", qin.tready, 1);
    check("rst_err", frame_err, 0);
    check("rst_rd_data", rd_data, 0);
    send_frame(8'h00, 16, 15);
    rd(0);
    rd(5);
    rd(15);
    release_bank();
    stalls = 0;
    for (int i = 0; i < 16; i++) send_beat(8'h10 + 8'(i), i == 15);
    for (int i = 0; i < 16; i++) send_beat(8'h20 + 8'(i), i == 15);
    qin.tvalid = 1'b0;
    qin.tlast = 1'b0;
    check("b2b_stalls", stalls, 0);
    rd(3);
    release_bank();
    rd(3);
    release_bank();
    send_frame(8'h30, 10, 9);
    release_bank();
    rd(0);
    rd(9);
    send_frame(8'h40, 16, -1);
    release_bank();
    rd(0);
    rd(15);
    release_bank();
    rd(5);
    send_frame(8'h50, 16, 15);
    send_frame(8'h60, 16, 15);
    qin.tvalid = 1'b1;
    qin.tdata = 8'hAA;
    qin.tlast = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("hold_tready", qin.tready, 0);
    end
    qin.tvalid = 1'b0;
    rd(0);
    rd(15);
    release_bank();
    rd(0);
    for (int i = 0; i < 5; i++) send_beat(8'h80 + 8'(i), 1'b0);
    qin.tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("mid_rst_valid", rd_bank_valid, 0);
    check("mid_rst_tready", qin.tready, 1);
    check("mid_rst_err", frame_err, 0);
`ifdef SOFTMAX_SINK_STATS_EN
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
`endif
    send_frame(8'h70, 16, 15);
    rd(0);
    rd(6);
    rd(15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
